// File: rtl/red_pitaya_sort_delay.sv
// Sort-delay scheduler: timestamps detector sort edges, queues them, then fires the ASG trigger
// and the HV gate after a programmable delay. Optional edge holdoff: define SORT_DELAY_HOLDOFF_EN.
module red_pitaya_sort_delay #(
   parameter int TW    = 32,
   parameter int QLOG2 = 3
) (
   input  logic        adc_clk_i,
   input  logic        adc_rstn_i,
   input  logic        sort_trig_i,
   output logic        asg_trig_o,
   output logic        sort_gate_o,
   output logic        queue_busy_o,
   input  logic [31:0] sys_addr,
   input  logic [31:0] sys_wdata,
   input  logic [3:0]  sys_sel,
   input  logic        sys_wen,
   input  logic        sys_ren,
   output logic [31:0] sys_rdata,
   output logic        sys_err,
   output logic        sys_ack
);

   localparam int             DEPTH    = 1 << QLOG2;
   localparam logic [TW-1:0]  CNT_MAX  = {TW{1'b1}};
   localparam logic [QLOG2:0] LVL_FULL = (QLOG2+1)'(DEPTH);

   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
      return (v == CNT_MAX) ? v : v + TW'(1);
   endfunction

   logic [TW-1:0]    r_ts, r_delay, r_width, r_wcnt;
   logic [TW-1:0]    r_issued_cnt, r_dropped_cnt, r_merged_cnt;
   logic [TW-1:0]    r_queue [DEPTH];
   logic [QLOG2-1:0] r_wptr, r_rptr;
   logic [QLOG2:0]   r_level;
   logic             r_enable, r_trig, r_trig_d, r_gate, r_asg, r_ack;
   logic [31:0]      r_rdata;

   logic [19:0]      w_addr;
   logic             w_wr_delay, w_wr_width, w_wr_ctrl, w_flush, w_clr;
   logic [TW-1:0]    w_d, w_w, w_head, w_diff;
   logic             w_due, w_pop, w_full, w_req, w_take, w_push, w_drop, w_merge, w_hold_rej;
   logic [31:0]      w_rdata;
   logic             w_unused;

   assign w_addr     = sys_addr[19:0];
   assign w_wr_delay = sys_wen && (w_addr == 20'h00000);
   assign w_wr_width = sys_wen && (w_addr == 20'h00004);
   assign w_wr_ctrl  = sys_wen && (w_addr == 20'h00008);
   assign w_flush    = w_wr_ctrl && sys_wdata[1];
   assign w_clr      = w_wr_ctrl && sys_wdata[2];

   assign w_d    = (r_delay < TW'(2)) ? TW'(2) : r_delay;
   assign w_w    = (r_width == TW'(0)) ? TW'(1) : r_width;
   assign w_head = r_queue[r_rptr];
   // Decide one cycle early so the registered outputs rise exactly when ts reaches the due time.
   assign w_diff = r_ts + TW'(1) - w_head;
   assign w_due  = (|r_level) && !w_diff[TW-1];
   assign w_pop  = w_due && !w_flush;
   assign w_full = (r_level == LVL_FULL);

   assign w_req   = r_trig && !r_trig_d && r_enable && !w_flush;
   assign w_take  = w_req && !w_hold_rej;
   assign w_push  = w_take && (!w_full || w_pop);
   assign w_drop  = w_take && w_full && !w_pop;
   assign w_merge = w_pop && r_gate;

   assign asg_trig_o   = r_asg;
   assign sort_gate_o  = r_gate;
   assign queue_busy_o = |r_level;
   assign sys_rdata    = r_rdata;
   assign sys_ack      = r_ack;
   assign sys_err      = 1'b0;
   assign w_unused     = ^{sys_sel, sys_addr[31:20], sys_wdata, w_diff};

`ifdef SORT_DELAY_HOLDOFF_EN
   logic [TW-1:0] r_holdoff, r_holdoff_cnt, r_last;
   logic          r_last_vld;
   logic          w_wr_holdoff;

   assign w_wr_holdoff = sys_wen && (w_addr == 20'h0001C);
   assign w_hold_rej   = (r_holdoff != TW'(0)) && r_last_vld && ((r_ts - r_last) < r_holdoff);

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         r_holdoff     <= TW'(0);
         r_holdoff_cnt <= TW'(0);
         r_last        <= TW'(0);
         r_last_vld    <= 1'b0;
      end else begin
         if (w_wr_holdoff)
            r_holdoff <= TW'(sys_wdata);
         if (w_take) begin
            r_last     <= r_ts;
            r_last_vld <= 1'b1;
         end
         if (w_clr)
            r_holdoff_cnt <= TW'(0);
         else if (w_req && w_hold_rej)
            r_holdoff_cnt <= sat_inc(r_holdoff_cnt);
      end
   end
`else
   assign w_hold_rej = 1'b0;
`endif

   always_ff @(posedge adc_clk_i) begin
      if (w_push)
         r_queue[r_wptr] <= r_ts + w_d;
   end

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         r_ts          <= TW'(0);
         r_delay       <= TW'(1000);
         r_width       <= TW'(100);
         r_enable      <= 1'b1;
         r_trig        <= 1'b0;
         r_trig_d      <= 1'b0;
         r_wcnt        <= TW'(0);
         r_gate        <= 1'b0;
         r_asg         <= 1'b0;
         r_wptr        <= QLOG2'(0);
         r_rptr        <= QLOG2'(0);
         r_level       <= (QLOG2+1)'(0);
         r_issued_cnt  <= TW'(0);
         r_dropped_cnt <= TW'(0);
         r_merged_cnt  <= TW'(0);
      end else begin
         r_ts     <= r_ts + TW'(1);
         r_trig   <= sort_trig_i;
         r_trig_d <= r_trig;
         if (w_wr_delay) r_delay  <= TW'(sys_wdata);
         if (w_wr_width) r_width  <= TW'(sys_wdata);
         if (w_wr_ctrl)  r_enable <= sys_wdata[0];

         // A pop during an active gate reloads the width, so the gate is extended rather than re-pulsed.
         if (w_flush) begin
            r_wcnt <= TW'(0);
            r_gate <= 1'b0;
            r_asg  <= 1'b0;
         end else if (w_pop) begin
            r_wcnt <= w_w;
            r_gate <= 1'b1;
            r_asg  <= 1'b1;
         end else begin
            r_asg <= 1'b0;
            if (r_wcnt != TW'(0)) begin
               r_wcnt <= r_wcnt - TW'(1);
               r_gate <= (r_wcnt > TW'(1));
            end else begin
               r_gate <= 1'b0;
            end
         end

         if (w_flush) begin
            r_wptr  <= QLOG2'(0);
            r_rptr  <= QLOG2'(0);
            r_level <= (QLOG2+1)'(0);
         end else begin
            if (w_push) r_wptr <= r_wptr + QLOG2'(1);
            if (w_pop)  r_rptr <= r_rptr + QLOG2'(1);
            case ({w_push, w_pop})
               2'b10:   r_level <= r_level + (QLOG2+1)'(1);
               2'b01:   r_level <= r_level - (QLOG2+1)'(1);
               default: r_level <= r_level;
            endcase
         end

         if (w_clr) begin
            r_issued_cnt  <= TW'(0);
            r_dropped_cnt <= TW'(0);
            r_merged_cnt  <= TW'(0);
         end else begin
            if (w_pop)   r_issued_cnt  <= sat_inc(r_issued_cnt);
            if (w_drop)  r_dropped_cnt <= sat_inc(r_dropped_cnt);
            if (w_merge) r_merged_cnt  <= sat_inc(r_merged_cnt);
         end
      end
   end

   always_comb begin
      w_rdata = 32'd0;
      case (w_addr)
         20'h00000: w_rdata = 32'(r_delay);
         20'h00004: w_rdata = 32'(r_width);
         20'h00008: w_rdata = {31'd0, r_enable};
         20'h0000C: w_rdata = 32'(r_issued_cnt);
         20'h00010: w_rdata = 32'(r_dropped_cnt);
         20'h00014: w_rdata = 32'(r_merged_cnt);
         20'h00018: begin
            w_rdata[QLOG2:0] = r_level;
            w_rdata[16]      = r_gate;
         end
`ifdef SORT_DELAY_HOLDOFF_EN
         20'h0001C: w_rdata = 32'(r_holdoff);
         20'h00020: w_rdata = 32'(r_holdoff_cnt);
`endif
         default:   w_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         r_ack   <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         r_ack   <= sys_wen | sys_ren;
         r_rdata <= w_rdata;
      end
   end

endmodule

// File: tb/tb_red_pitaya_sort_delay.sv
// Self-checking bench for red_pitaya_sort_delay: scenario table plus directed flush, enable,
// holdoff (SORT_DELAY_HOLDOFF_EN), timestamp-wrap and mid-operation reset sequences.
module tb_red_pitaya_sort_delay;
   localparam int QLOG2 = 3;

   typedef struct {
      int delay; int width; int n; int gap;
      int first; int pulses; int gate_cyc; int peak;
      int issued; int dropped; int merged;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trig = 1'b0;
   logic        asg, gate, busy, err, ack;
   logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
   logic [3:0]  sel = 4'hF;
   logic        wen = 1'b0, ren = 1'b0;

   logic        wtrig = 1'b0, wwen = 1'b0, wren = 1'b0;
   logic        wasg, wgate, wbusy, werr, wack;
   logic [31:0] waddr = 32'd0, wwdata = 32'd0, wrdata;

   int checks = 0, errors = 0, cyc = 0, cyc0 = 0;
   int pulses, first, gcyc, peak;
   vec_t tbl [6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   red_pitaya_sort_delay #(.TW(32), .QLOG2(QLOG2)) dut (
      .adc_clk_i(clk), .adc_rstn_i(rst_n), .sort_trig_i(trig),
      .asg_trig_o(asg), .sort_gate_o(gate), .queue_busy_o(busy),
      .sys_addr(addr), .sys_wdata(wdata), .sys_sel(sel), .sys_wen(wen), .sys_ren(ren),
      .sys_rdata(rdata), .sys_err(err), .sys_ack(ack));

   // Narrow timestamp instance so the wrap happens within a short run.
   red_pitaya_sort_delay #(.TW(8), .QLOG2(QLOG2)) u_wrap (
      .adc_clk_i(clk), .adc_rstn_i(rst_n), .sort_trig_i(wtrig),
      .asg_trig_o(wasg), .sort_gate_o(wgate), .queue_busy_o(wbusy),
      .sys_addr(waddr), .sys_wdata(wwdata), .sys_sel(sel), .sys_wen(wwen), .sys_ren(wren),
      .sys_rdata(wrdata), .sys_err(werr), .sys_ack(wack));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; wen = 1'b1;
      tick();
      wen = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      addr = a; ren = 1'b1;
      tick();
      ren = 1'b0;
      chk({name, "_ack"}, 32'(ack), 32'd1);
      chk(name, rdata, exp);
   endtask

   task automatic clr_obs();
      pulses = 0; first = -1; gcyc = 0; peak = 0;
   endtask

   task automatic obs(input int j);
      if (asg) begin
         pulses++;
         if (first < 0) first = j;
      end
      if (gate) gcyc++;
      if (int'(rdata[QLOG2:0]) > peak) peak = int'(rdata[QLOG2:0]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int wp, wf, wg, guard;
      tbl[0] = '{10, 5, 1, 1, 11, 1,  5, 1, 1, 0, 0};
      tbl[1] = '{20, 3, 9, 2, 21, 8, 17, 8, 8, 1, 7};
      tbl[2] = '{10, 8, 2, 4, 11, 2, 12, 2, 2, 0, 1};
      tbl[3] = '{ 0, 0, 1, 1,  3, 1,  1, 1, 1, 0, 0};
      tbl[4] = '{ 1, 2, 1, 1,  3, 1,  2, 1, 1, 0, 0};
      tbl[5] = '{10, 3, 2, 6, 11, 2,  6, 2, 2, 0, 0};

      // Reset state
      repeat (3) tick();
      chk("rst_asg", 32'(asg), 32'd0);
      chk("rst_gate", 32'(gate), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      cyc0 = cyc;
      tick();
      rd_chk("rst_delay", 32'h00, 32'd1000);
      rd_chk("rst_width", 32'h04, 32'd100);
      rd_chk("rst_ctrl", 32'h08, 32'd1);
      rd_chk("rst_issued", 32'h0C, 32'd0);
      rd_chk("rst_dropped", 32'h10, 32'd0);
      rd_chk("rst_merged", 32'h14, 32'd0);
      rd_chk("rst_status", 32'h18, 32'd0);
      rd_chk("unmapped_rd", 32'h40, 32'd0);

      // Scenario table
      for (int i = 0; i < 6; i++) begin
         bus_wr(32'h00, 32'(tbl[i].delay));
         bus_wr(32'h04, 32'(tbl[i].width));
         bus_wr(32'h08, 32'h5);
         addr = 32'h18; ren = 1'b1;
         tick(); tick();
         clr_obs();
         for (int j = 0; j < 60; j++) begin
            obs(j);
            trig = (j < tbl[i].n * tbl[i].gap) && (j % tbl[i].gap == 0);
            tick();
         end
         trig = 1'b0; ren = 1'b0;
         $display("scenario %0d: delay=%0d width=%0d edges=%0d", i, tbl[i].delay, tbl[i].width, tbl[i].n);
         chk("first_asg", 32'(first), 32'(tbl[i].first));
         chk("asg_pulses", 32'(pulses), 32'(tbl[i].pulses));
         chk("gate_cycles", 32'(gcyc), 32'(tbl[i].gate_cyc));
         chk("level_peak", 32'(peak), 32'(tbl[i].peak));
         chk("busy_idle", 32'(busy), 32'd0);
         rd_chk("issued", 32'h0C, 32'(tbl[i].issued));
         rd_chk("dropped", 32'h10, 32'(tbl[i].dropped));
         rd_chk("merged", 32'h14, 32'(tbl[i].merged));
      end

      // Flush with three queued entries and an edge in the flush cycle
      bus_wr(32'h00, 32'd30); bus_wr(32'h04, 32'd4); bus_wr(32'h08, 32'h5);
      tick();
      clr_obs();
      for (int j = 0; j < 70; j++) begin
         obs(j);
         if (j == 8) chk("busy_before_flush", 32'(busy), 32'd1);
         if (j == 9) chk("busy_after_flush", 32'(busy), 32'd0);
         trig = (j == 0 || j == 2 || j == 4 || j == 7);
         addr = 32'h08; wdata = 32'h3; wen = (j == 8);
         tick();
      end
      wen = 1'b0; trig = 1'b0;
      chk("flush_pulses", 32'(pulses), 32'd0);
      chk("flush_gate", 32'(gcyc), 32'd0);
      rd_chk("flush_issued", 32'h0C, 32'd0);
      rd_chk("flush_status", 32'h18, 32'd0);
      rd_chk("flush_ctrl", 32'h08, 32'd1);

      // Disable after queuing: queued entry still fires, new edge ignored
      bus_wr(32'h00, 32'd20); bus_wr(32'h04, 32'd2); bus_wr(32'h08, 32'h5);
      tick();
      clr_obs();
      for (int j = 0; j < 50; j++) begin
         obs(j);
         trig = (j == 0 || j == 10);
         addr = 32'h08; wdata = 32'h0; wen = (j == 5);
         tick();
      end
      wen = 1'b0; trig = 1'b0;
      chk("dis_first", 32'(first), 32'd21);
      chk("dis_pulses", 32'(pulses), 32'd1);
      chk("dis_gate", 32'(gcyc), 32'd2);
      rd_chk("dis_issued", 32'h0C, 32'd1);
      rd_chk("dis_dropped", 32'h10, 32'd0);
      bus_wr(32'h08, 32'h1);

      // Holdoff: edges at +0, +30, +60 with holdoff=50
      bus_wr(32'h00, 32'd10); bus_wr(32'h04, 32'd2); bus_wr(32'h08, 32'h5);
      bus_wr(32'h1C, 32'd50);
      tick();
      clr_obs();
      for (int j = 0; j < 90; j++) begin
         obs(j);
         trig = (j == 0 || j == 30 || j == 60);
         tick();
      end
      trig = 1'b0;
      chk("hold_first", 32'(first), 32'd11);
`ifdef SORT_DELAY_HOLDOFF_EN
      chk("hold_pulses", 32'(pulses), 32'd2);
      rd_chk("hold_cnt", 32'h20, 32'd1);
      rd_chk("hold_reg", 32'h1C, 32'd50);
      rd_chk("hold_issued", 32'h0C, 32'd2);
      bus_wr(32'h1C, 32'd0);
`else
      chk("hold_pulses", 32'(pulses), 32'd3);
      rd_chk("hold_cnt", 32'h20, 32'd0);
      rd_chk("hold_reg", 32'h1C, 32'd0);
      rd_chk("hold_issued", 32'h0C, 32'd3);
`endif

      // Timestamp wrap on the 8-bit instance: push near 2^8-5, due time wraps to a small value
      waddr = 32'h00; wwdata = 32'd10; wwen = 1'b1; tick();
      waddr = 32'h04; wwdata = 32'd2; tick();
      wwen = 1'b0;
      waddr = 32'h00; wren = 1'b1; tick();
      wren = 1'b0;
      chk("wrap_ack", 32'(wack), 32'd1);
      chk("wrap_delay_rd", wrdata, 32'd10);
      guard = 0;
      while (((cyc - cyc0) % 256) != 248 && guard < 600) begin
         tick();
         guard++;
      end
      wp = 0; wf = -1; wg = 0;
      for (int j = 0; j < 30; j++) begin
         if (wasg) begin
            wp++;
            if (wf < 0) wf = j;
         end
         if (wgate) wg++;
         wtrig = (j == 0);
         tick();
      end
      chk("wrap_first", 32'(wf), 32'd11);
      chk("wrap_pulses", 32'(wp), 32'd1);
      chk("wrap_gate", 32'(wg), 32'd2);
      chk("wrap_busy", 32'(wbusy), 32'd0);
      chk("wrap_err", 32'(werr), 32'd0);

      // Reset during an active gate with an entry still pending
      bus_wr(32'h00, 32'd10); bus_wr(32'h04, 32'd20); bus_wr(32'h08, 32'h5);
      tick();
      for (int j = 0; j < 13; j++) begin
         trig = (j == 0 || j == 4);
         tick();
      end
      trig = 1'b0;
      chk("pre_rst_gate", 32'(gate), 32'd1);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_gate", 32'(gate), 32'd0);
      chk("mid_rst_asg", 32'(asg), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      clr_obs();
      for (int j = 0; j < 40; j++) begin
         obs(j);
         tick();
      end
      chk("post_rst_pulses", 32'(pulses), 32'd0);
      chk("post_rst_gate", 32'(gcyc), 32'd0);
      rd_chk("post_rst_delay", 32'h00, 32'd1000);
      rd_chk("post_rst_issued", 32'h0C, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/red_pitaya_sort_delay.md
Name: red_pitaya_sort_delay

Overview:
- Downstream stage of the FADS detector: consumes its sort trigger and schedules the actual sorting actuation.
- Droplets reach the sorting junction a fixed time after detection, and several may be in flight at once. Each trigger edge is therefore timestamped and queued.
- After a programmable delay, the block emits a one-cycle ASG trigger and a programmable-width gate that enables the high-voltage amplifier path.
- Configuration and counters are exposed on the system bus.

Parameters:
- TW, 32, width of the timestamp counter, delay/width registers and all event counters.
- QLOG2, 3, log2 of pending-sort queue depth (default 8 entries).

Ports:
- adc_clk_i  in  1  ADC clock; the only clock.
- adc_rstn_i  in  1  reset, asynchronous assert, active-low.
- sort_trig_i  in  1  sort request from the detector; rising edge = one sort.
- asg_trig_o  out  1  one-cycle pulse to the ASG trigger input.
- sort_gate_o  out  1  high while sorting actuation is active.
- queue_busy_o  out  1  high while the queue is non-empty.
- sys_addr  in  32  bus address.
- sys_wdata  in  32  bus write data.
- sys_sel  in  4  byte select; ignored, full-word writes only.
- sys_wen  in  1  bus write enable.
- sys_ren  in  1  bus read enable.
- sys_rdata  out  32  bus read data.
- sys_err  out  1  bus error; always 0.
- sys_ack  out  1  bus acknowledge.

Behaviour:
- Reset: all outputs 0; queue empty; timestamp counter, counters and edge register 0.
- Register defaults at reset: delay=1000, width=100, enable=1.
- Timestamp counter ts: free-running, +1 per cycle, wraps modulo 2^TW.
- Edge detect: sort_trig_i is registered once. An accepted edge is the cycle n where the registered value is 1 and its previous value was 0.
- Push: on an accepted edge with enable=1, push due = ts + D, where D = max(delay,2).
  - Queue full: the edge is dropped and dropped_cnt increments.
  - Pop and push in the same cycle while full: both succeed.
- Due test: the head entry is due when (ts − head), taken as a signed TW-bit value, is ≥ 0. This survives ts wrap and non-monotonic entries after a delay change.
- Pop: at most one entry per cycle. On pop:
  - asg_trig_o = 1 for exactly that cycle.
  - sort_gate_o rises in the same cycle.
  - The width counter loads W = max(width,1).
  - issued_cnt increments.
- Required timing: an isolated edge first sampled at sort_trig_i on cycle k gives asg_trig_o and sort_gate_o rising on cycle k+1+D. The gate stays high exactly W cycles.
- Overlap: a pop while the gate is already high reloads the width counter to W (the gate is extended, not re-pulsed low), pulses asg_trig_o again, and increments merged_cnt.
- enable=0: new edges are ignored and not counted; already-queued entries still fire.
- Flush (write 1 to ctrl bit1, self-clearing): on the next cycle the queue empties, sort_gate_o drops, the width counter clears and no asg_trig_o fires. An edge in the same cycle as the flush is discarded.
- Clear counters (ctrl bit2, self-clearing): zeroes issued_cnt, dropped_cnt and merged_cnt. An increment in the same cycle is lost.
- Counters saturate at 2^TW−1.
- Register changes affect only future pushes and pops; queued due times are unchanged.
- Bus:
  - sys_ack = registered (sys_wen|sys_ren), one cycle after the request.
  - sys_rdata is registered from sys_addr[19:0].
  - Unmapped reads return 0; unmapped writes are ignored.
- Register map:
  - 0x00 delay (RW)
  - 0x04 width (RW)
  - 0x08 ctrl (bit0 enable RW; bits 1 and 2 write-only, read 0)
  - 0x0C issued_cnt (RO)
  - 0x10 dropped_cnt (RO)
  - 0x14 merged_cnt (RO)
  - 0x18 status: [QLOG2:0] queue level, bit16 gate
- Reset mid-operation: everything returns to reset state asynchronously. Pending sorts are lost and the outputs drop immediately.

Optional Feature:
- Macro: SORT_DELAY_HOLDOFF_EN.
- Defined:
  - Adds register 0x1C holdoff (RW, reset 0) and 0x20 holdoff_cnt (RO, saturating, cleared by ctrl bit2).
  - An edge arriving fewer than holdoff cycles after the last accepted edge is rejected: it is not queued, and holdoff_cnt increments.
  - holdoff=0 disables the check.
- Undefined: no holdoff logic; 0x1C and 0x20 read 0 and writes are ignored.

Test Plan:
- delay=10, width=5, single edge first sampled at cycle 100 -> asg_trig_o high only at cycle 111; sort_gate_o high cycles 111–115; issued_cnt=1.
- delay=20, width=3, 9 edges spaced 2 cycles apart -> 8 sorts emitted 2 cycles apart; dropped_cnt=1; status level peaks at 8.
- delay=10, width=8, two edges 4 cycles apart -> gate high continuously for 12 cycles; two asg_trig_o pulses; merged_cnt=1.
- delay=0, width=0 -> treated as D=2, W=1; edge at cycle k gives a one-cycle gate at k+3.
- ts preloaded near 2^32−5 via forced reset sequence, delay=10 -> sort fires correctly across the wrap; no spurious early pop.
- 3 entries queued, then ctrl write 0x3 -> no further asg_trig_o; queue_busy_o low next cycle; an edge in the flush cycle is discarded.
- SORT_DELAY_HOLDOFF_EN defined, holdoff=50, edges at +0, +30, +60 -> 2 sorts; holdoff_cnt=1.
